// File: rtl/clockntrigger_multi_if.sv
// Bundles the per-channel trigger inputs, configuration fields and the
// divided-clock status outputs of the multi-channel triggered clock
// generator. All signals live in the fastclk domain except trigger, which
// is asynchronous and is synchronised inside the block.
interface clockntrigger_multi_if #(
    parameter int N_CH  = 4,
    parameter int DIV_W = 8,
    parameter int CNT_W = 8
);
    logic [N_CH-1:0]       trigger;
    logic [N_CH-1:0]       mode;
    logic [N_CH*DIV_W-1:0] divide;
    logic [N_CH*DIV_W-1:0] high_time;
    logic [N_CH*CNT_W-1:0] burst_len;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       done;

    // Trigger source / configuration side.
    modport master (
        output trigger, mode, divide, high_time, burst_len,
        input  clk_out, busy, done
    );

    // Clock generator side.
    modport slave (
        input  trigger, mode, divide, high_time, burst_len,
        output clk_out, busy, done
    );
endinterface

// File: rtl/clockntrigger_multi.sv
// Multi-channel triggered clock generator. Each channel synchronises its
// trigger, then runs an IDLE/RUN/FINISH FSM that produces a registered
// divided clock with programmable period and high time. Gated mode runs
// whole periods while the trigger stays high; burst mode launches a fixed
// number of periods on a trigger rising edge.
module clockntrigger_multi #(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 8,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic                  fastclk,
    input logic                  reset,
    clockntrigger_multi_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    logic [N_CH-1:0] clk_out_v;
    logic [N_CH-1:0] busy_v;
    logic [N_CH-1:0] done_v;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_prev_q;
        logic                   level;
        logic                   rise;

        logic                   mode_in;
        logic [DIV_W-1:0]       div_in;
        logic [DIV_W-1:0]       high_in;
        logic [CNT_W-1:0]       len_in;
        logic [DIV_W-1:0]       div_clamp;
        logic [DIV_W-1:0]       high_clamp;

        logic                   mode_q;
        logic [DIV_W-1:0]       div_q;
        logic [DIV_W-1:0]       high_q;
        logic [CNT_W-1:0]       len_q;

        state_t                 state_q, state_d;
        logic [DIV_W-1:0]       phase_q, phase_d;
        logic [CNT_W-1:0]       count_q, count_d;
        logic                   load;
        logic                   start;
        logic                   clk_q;
        logic                   done_q;

        assign mode_in = bus.mode[i];
        assign div_in  = bus.divide[i*DIV_W +: DIV_W];
        assign high_in = bus.high_time[i*DIV_W +: DIV_W];
        assign len_in  = bus.burst_len[i*CNT_W +: CNT_W];

        // Trigger synchroniser plus one extra flop for rising-edge detection.
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values and the chain shifts by exactly one stage.
        always_ff @(posedge fastclk or negedge reset) begin
            if (!reset) begin
                sync_q      <= '0;
                sync_prev_q <= 1'b0;
            end else begin
                sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.trigger[i]};
                sync_prev_q <= sync_q[SYNC_STAGES-1];
            end
        end

        assign level = sync_q[SYNC_STAGES-1];
        assign rise  = level & ~sync_prev_q;
        assign start = mode_in ? rise : level;

        // Clamp the live configuration so a latched setting never yields a
        // zero-width or always-high pulse.
        always_comb begin
            div_clamp = (div_in < DIV_W'(2)) ? DIV_W'(2) : div_in;
            if (high_in == '0) begin
                high_clamp = DIV_W'(1);
            end else if (high_in >= div_clamp) begin
                high_clamp = div_clamp - DIV_W'(1);
            end else begin
                high_clamp = high_in;
            end
        end

        // Configuration captured once per run; later input changes are ignored.
        always_ff @(posedge fastclk or negedge reset) begin
            if (!reset) begin
                mode_q <= 1'b0;
                div_q  <= DIV_W'(2);
                high_q <= DIV_W'(1);
                len_q  <= '0;
            end else if (load) begin
                mode_q <= mode_in;
                div_q  <= div_clamp;
                high_q <= high_clamp;
                len_q  <= len_in;
            end
        end

        // Next-state logic: start detection, phase wrap and run termination.
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        always_comb begin
            state_d = state_q;
            phase_d = phase_q;
            count_d = count_q;
            load    = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        load    = 1'b1;
                        phase_d = '0;
                        count_d = '0;
                        state_d = (mode_in && len_in == '0) ? FINISH : RUN;
                    end
                end
                RUN: begin
                    if (phase_q == div_q - DIV_W'(1)) begin
                        phase_d = '0;
                        if (mode_q) begin
                            count_d = count_q + CNT_W'(1);
                            if (count_q + CNT_W'(1) == len_q) state_d = FINISH;
                        end else if (!level) begin
                            state_d = FINISH;
                        end
                    end else begin
                        phase_d = phase_q + DIV_W'(1);
                    end
                end
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // FSM state and counters.
        always_ff @(posedge fastclk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                phase_q <= '0;
                count_q <= '0;
            end else begin
                state_q <= state_d;
                phase_q <= phase_d;
                count_q <= count_d;
            end
        end

        // Registered outputs: divided clock from the current phase, and a
        // one-cycle done pulse on the FINISH -> IDLE transition.
        always_ff @(posedge fastclk or negedge reset) begin
            if (!reset) begin
                clk_q  <= 1'b0;
                done_q <= 1'b0;
            end else begin
                clk_q  <= (state_q == RUN) && (phase_q < high_q);
                done_q <= (state_q == FINISH);
            end
        end

        assign clk_out_v[i] = clk_q;
        assign busy_v[i]    = (state_q != IDLE);
        assign done_v[i]    = done_q;
    end

    assign bus.clk_out = clk_out_v;
    assign bus.busy    = busy_v;
    assign bus.done    = done_v;

endmodule

// File: tb/tb_clockntrigger_multi.sv
// Directed bench for clockntrigger_multi. Each table row describes one
// channel scenario (configuration, trigger windows) together with the
// hand-derived timing of its runs: edge of the first high output, number of
// full periods, and the effective (clamped) divide/high values. Rows sharing
// a group id run simultaneously on different channels.
module tb_clockntrigger_multi;

    localparam int N_CH        = 4;
    localparam int DIV_W       = 8;
    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int GROUP_EDGES = 40;
    localparam int MULTI_GRP   = 8;
    localparam int N_GROUPS    = 9;

    typedef struct {
        int grp;
        int ch;
        bit mode;
        int div;
        int hi;
        int len;
        int w1a, w1b;     // trigger sampled high at edges [w1a, w1b)
        int w2a, w2b;     // optional second window (w2a == w2b: none)
        int first1, n1;   // first run: edge of first high output, periods
        int first2, n2;   // second run (n2 < 0: none)
        int eff_div;
        int eff_hi;
    } row_t;

    logic fastclk;
    logic reset;
    row_t tbl[$];
    int   total_checks;
    int   bad_checks;

    clockntrigger_multi_if #(.N_CH(N_CH), .DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    clockntrigger_multi #(
        .N_CH(N_CH), .DIV_W(DIV_W), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .fastclk (fastclk),
        .reset   (reset),
        .bus     (bus)
    );

    initial fastclk = 1'b0;
    always #5 fastclk = ~fastclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            bad_checks++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_row(input int grp, input int ch, input bit mode, input int div,
                           input int hi, input int len, input int w1a, input int w1b,
                           input int w2a, input int w2b, input int first1, input int n1,
                           input int first2, input int n2, input int eff_div, input int eff_hi);
        row_t r;
        r.grp = grp; r.ch = ch; r.mode = mode; r.div = div; r.hi = hi; r.len = len;
        r.w1a = w1a; r.w1b = w1b; r.w2a = w2a; r.w2b = w2b;
        r.first1 = first1; r.n1 = n1; r.first2 = first2; r.n2 = n2;
        r.eff_div = eff_div; r.eff_hi = eff_hi;
        tbl.push_back(r);
    endtask

    function automatic logic trig_at(input row_t r, input int e);
        return (e >= r.w1a && e < r.w1b) || (e >= r.w2a && e < r.w2b);
    endfunction

    // Expected outputs after edge e for a channel following row r.
    function automatic logic [2:0] expect_at(input row_t r, input int e);
        logic clk_e, busy_e, done_e;
        clk_e = 1'b0; busy_e = 1'b0; done_e = 1'b0;
        for (int k = 0; k < 2; k++) begin
            int f, n, end_e;
            f = (k == 0) ? r.first1 : r.first2;
            n = (k == 0) ? r.n1 : r.n2;
            if (n >= 0) begin
                end_e = f + n * r.eff_div;
                if (e >= f && e < end_e && ((e - f) % r.eff_div) < r.eff_hi) clk_e = 1'b1;
                if (e >= f - 1 && e < end_e) busy_e = 1'b1;
                if (e == end_e) done_e = 1'b1;
            end
        end
        return {clk_e, busy_e, done_e};
    endfunction

    task automatic drive_trigger(input int rid[N_CH], input int e);
        logic [N_CH-1:0] tv;
        tv = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (rid[c] >= 0) tv[c] = trig_at(tbl[rid[c]], e);
        end
        bus.trigger = tv;
    endtask

    task automatic run_group(input int g);
        int         rid[N_CH];
        logic [2:0] exp_v;
        for (int c = 0; c < N_CH; c++) rid[c] = -1;
        foreach (tbl[k]) begin
            if (tbl[k].grp == g) begin
                rid[tbl[k].ch] = k;
                bus.mode[tbl[k].ch]                       = tbl[k].mode;
                bus.divide[tbl[k].ch*DIV_W +: DIV_W]      = DIV_W'(tbl[k].div);
                bus.high_time[tbl[k].ch*DIV_W +: DIV_W]   = DIV_W'(tbl[k].hi);
                bus.burst_len[tbl[k].ch*CNT_W +: CNT_W]   = CNT_W'(tbl[k].len);
            end
        end
        @(negedge fastclk);
        drive_trigger(rid, 0);
        for (int e = 0; e < GROUP_EDGES; e++) begin
            @(posedge fastclk);
            #1;
            for (int c = 0; c < N_CH; c++) begin
                exp_v = (rid[c] >= 0) ? expect_at(tbl[rid[c]], e) : 3'b000;
                check($sformatf("g%0d e%0d ch%0d clk_out", g, e, c), 32'(bus.clk_out[c]), 32'(exp_v[2]));
                check($sformatf("g%0d e%0d ch%0d busy", g, e, c),    32'(bus.busy[c]),    32'(exp_v[1]));
                check($sformatf("g%0d e%0d ch%0d done", g, e, c),    32'(bus.done[c]),    32'(exp_v[0]));
            end
            // Reprogram every channel mid-run; latched settings must hold.
            if (g == MULTI_GRP && e == 4) begin
                bus.mode      = ~bus.mode;
                bus.divide    = {N_CH{DIV_W'(9)}};
                bus.high_time = {N_CH{DIV_W'(1)}};
                bus.burst_len = {N_CH{CNT_W'(1)}};
            end
            drive_trigger(rid, e + 1);
        end
    endtask

    initial begin
        int seen;
        int done_cnt;
        total_checks = 0;
        bad_checks   = 0;

        //      grp ch mode div hi len  w1     w2     first1 n1 first2 n2  eff
        add_row(0, 0, 1'b0, 4, 2, 0,  0, 12,  0, 0,  3, 3,  0, -1,  4, 2);  // gated, 12 cycles
        add_row(1, 0, 1'b0, 4, 2, 0,  0, 13,  0, 0,  3, 4,  0, -1,  4, 2);  // gated, drop mid-period
        add_row(2, 1, 1'b1, 3, 1, 5,  0, 1,   6, 7,  3, 5,  0, -1,  3, 1);  // burst + ignored retrigger
        add_row(3, 2, 1'b0, 1, 0, 0,  0, 6,   0, 0,  3, 3,  0, -1,  2, 1);  // clamp divide=1, high=0
        add_row(4, 2, 1'b1, 5, 9, 2,  0, 1,   0, 0,  3, 2,  0, -1,  5, 4);  // clamp high>=divide
        add_row(5, 3, 1'b1, 4, 1, 0,  0, 1,   0, 0,  3, 0,  0, -1,  4, 1);  // burst_len=0
        add_row(6, 1, 1'b1, 6, 6, 1,  0, 1,   0, 0,  3, 1,  0, -1,  6, 5);  // high==divide
        add_row(7, 0, 1'b0, 2, 1, 0,  0, 2,   8, 10, 3, 1,  11, 1,  2, 1);  // gated restart after done
        add_row(8, 0, 1'b0, 3, 2, 0,  0, 9,   0, 0,  3, 3,  0, -1,  3, 2);  // all channels at once
        add_row(8, 1, 1'b1, 4, 3, 3,  0, 1,   0, 0,  3, 3,  0, -1,  4, 3);
        add_row(8, 2, 1'b1, 2, 1, 4,  0, 3,   0, 0,  3, 4,  0, -1,  2, 1);
        add_row(8, 3, 1'b0, 5, 1, 0,  0, 4,   0, 0,  3, 1,  0, -1,  5, 1);

        bus.trigger   = '0;
        bus.mode      = '0;
        bus.divide    = {N_CH{DIV_W'(4)}};
        bus.high_time = {N_CH{DIV_W'(2)}};
        bus.burst_len = {N_CH{CNT_W'(1)}};
        reset         = 1'b0;

        // Held in reset with triggers toggling: outputs stay quiet.
        for (int i = 0; i < 3; i++) begin
            @(posedge fastclk);
            #1;
            check($sformatf("rst hold %0d clk_out", i), 32'(bus.clk_out), 32'd0);
            check($sformatf("rst hold %0d busy", i),    32'(bus.busy),    32'd0);
            check($sformatf("rst hold %0d done", i),    32'(bus.done),    32'd0);
            bus.trigger = ~bus.trigger;
        end
        bus.trigger = '0;
        @(negedge fastclk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge fastclk);
            #1;
            check($sformatf("post rst %0d outputs", i),
                  32'({bus.clk_out, bus.busy, bus.done}), 32'd0);
        end

        for (int g = 0; g < N_GROUPS; g++) run_group(g);

        // Reset asserted mid-burst: output drops at once, no done afterwards.
        bus.mode[1]                  = 1'b1;
        bus.divide[1*DIV_W +: DIV_W] = DIV_W'(2);
        bus.high_time[1*DIV_W +: DIV_W] = DIV_W'(1);
        bus.burst_len[1*CNT_W +: CNT_W] = CNT_W'(20);
        @(negedge fastclk);
        bus.trigger[1] = 1'b1;
        @(posedge fastclk);
        #1;
        bus.trigger[1] = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(posedge fastclk);
            #1;
            if (bus.clk_out[1]) seen = 1;
        end
        check("midburst clk_out seen", 32'(seen), 32'd1);
        reset = 1'b0;
        #1;
        check("midburst clk_out after reset", 32'(bus.clk_out[1]), 32'd0);
        check("midburst busy after reset",    32'(bus.busy[1]),    32'd0);
        done_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge fastclk);
            #1;
            if (bus.done[1]) done_cnt++;
        end
        @(negedge fastclk);
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge fastclk);
            #1;
            if (bus.done[1]) done_cnt++;
        end
        check("midburst done pulses", 32'(done_cnt), 32'd0);
        check("midburst busy at end", 32'(bus.busy[1]), 32'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/clockntrigger_multi.md
Name: clockntrigger_multi

Overview:
Multi-channel, parametrised successor to the single triggered clock generator. Each channel derives a divided clock from fastclk with a programmable period and high time. A channel is enabled by its own trigger input in one of two modes: gated (runs while trigger is high) or burst (a trigger rising edge launches N periods). It sits between the trigger sources and downstream sampling/strobe logic, all in the fastclk domain.

Parameters:
N_CH, 4, number of independent channels
DIV_W, 8, width of period/high-time fields (period up to 2^DIV_W-1 fastclk cycles)
CNT_W, 8, width of burst-length field
SYNC_STAGES, 2, trigger synchroniser depth (>=2)

Ports:
fastclk  in  1  sole clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
trigger  in  N_CH  per-channel trigger, asynchronous to fastclk
mode  in  N_CH  per channel: 0 = gated, 1 = burst
divide  in  N_CH*DIV_W  per-channel period in fastclk cycles; channel i at [i*DIV_W +: DIV_W]
high_time  in  N_CH*DIV_W  per-channel high cycles per period
burst_len  in  N_CH*CNT_W  per-channel period count for burst mode
clk_out  out  N_CH  registered divided clock per channel
busy  out  N_CH  channel in RUN or FINISH
done  out  N_CH  1-cycle pulse when a channel returns to IDLE

Behaviour:
- Reset (reset=0, asynchronous): clk_out=0, busy=0, done=0, synchronisers cleared, all FSMs IDLE, counters 0. Assertion mid-operation stops output immediately. Exit from reset is synchronous to fastclk.
- trigger[i] passes through SYNC_STAGES flops, then a rise/level detector on the synchronised value.
- Config latch: in IDLE on a start event, latch mode, divide, high_time, burst_len. Changes while busy have no effect until the next start.
- Clamping on latch: divide<2 -> 2. high_time=0 -> 1. high_time>=divide -> divide-1. No zero-width or 100% pulses.
- Per-channel FSM IDLE/RUN/FINISH, with phase counter 0..divide-1 and period counter.
  - IDLE: clk_out=0. Start event is the synchronised trigger level=1 (gated) or its rising edge (burst). Start -> RUN, phase=0.
  - RUN: clk_out=1 while phase<high_time, else 0. Phase wraps divide-1 -> 0.
  - Gated mode: if synchronised trigger is 0 when phase wraps to 0, go to FINISH. A trigger drop mid-period never truncates the period.
  - Burst mode: increment period count at each wrap. After burst_len completed periods, go to FINISH.
  - burst_len=0: start goes straight to FINISH with no pulses.
  - FINISH: 1 cycle; clk_out=0, busy=1, done=1 registered on exit to IDLE. busy=0 in the cycle done=1.
- Latency: first clk_out=1 appears SYNC_STAGES+1 fastclk rising edges after the first edge that samples trigger=1.
- Burst retrigger: edges while busy are ignored, not queued. A rising edge is needed again after IDLE.
- Gated retrigger: trigger high in IDLE after done restarts the channel. Minimum 1 idle cycle between runs.
- Channels are fully independent; simultaneous triggers on all channels are legal.
- clk_out is a registered logic signal, not for use as a global clock without a buffer.

Test Plan:
- Reset: hold reset=0 for 3 cycles with triggers toggling -> clk_out=busy=done=0 throughout. Assert reset=0 mid-burst -> clk_out drops within the same cycle, no done pulse.
- Gated, ch0: divide=4, high_time=2, trigger high 12 cycles -> first high at edge 3 after sampling; exactly 3 periods of 1100; then FINISH, done pulse, idle.
- Gated, ch0, trigger high 13 cycles: trigger drops mid-period 4 -> period 4 completes, giving 4 full 1100 periods. No runt pulse.
- Burst, ch1: divide=3, high_time=1, burst_len=5, trigger 1-cycle-wide pulse -> 5 pulses of pattern 100. done=1 one cycle after the last period; a second trigger edge during the burst adds nothing.
- Clamps: divide=1 with high_time=0 -> behaves as divide=2/high=1 (1010...). divide=5 with high_time=9 -> 11110. burst_len=0 -> done pulse, no clk_out.
- All 4 channels triggered on the same cycle with distinct settings -> each channel's output matches its standalone reference model cycle-for-cycle.
